fsm_input_ctrl: RTL and testbench

Input-conditioning controller that sits between the chip pins (`ui_in[3:0]`) and the LED FSM core. It synchronises the push-button and the 3-bit switch bank, and debounces the button with a press/release state machine. It hands the FSM a single-cycle press pulse plus a switch value that is frozen at the moment the press is accepted. It also keeps a wrapping count of accepted presses and a busy flag for debug.

---
 rtl/fsm_ctrl_pkg.sv | 14 +
 rtl/sync2.sv | 26 ++
 rtl/fsm_input_ctrl.sv | 123 ++++++++++++
 tb/tb_fsm_input_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_ctrl_pkg.sv
// Shared types and constants for the LED FSM input-conditioning block.
package fsm_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StDbPress   = 2'd1,
      StPressed   = 2'd2,
      StDbRelease = 2'd3
   } db_state_t;

   localparam int unsigned SW_W = 3;
   localparam int unsigned DB_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser for asynchronous pin inputs.
module sync2 #(
   parameter int unsigned Width = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/fsm_input_ctrl.sv
// Button debouncer and switch latch feeding the LED FSM core: one pulse per accepted press,
// with the switch value frozen on that same edge.
module fsm_input_ctrl
   import fsm_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             btn_raw,
   input  logic [SW_W-1:0]  sw_raw,
   output logic             btn_pulse,
   output logic [SW_W-1:0]  sw_q,
   output logic [CNT_W-1:0] press_cnt,
   output logic             busy
);

   localparam int unsigned DbW = $clog2(DB_CYCLES);
   localparam logic [DbW-1:0] DbMax = DbW'(DB_CYCLES - 1);

   logic [SW_W:0]   sync_out;
   logic            btn_s;
   logic [SW_W-1:0] sw_s;

   sync2 #(
      .Width(SW_W + 1)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    ({btn_raw, sw_raw}),
      .q    (sync_out)
   );

   assign btn_s = sync_out[SW_W];
   assign sw_s  = sync_out[SW_W-1:0];

   db_state_t        state_q, state_d;
   logic [DbW-1:0]   db_cnt_q, db_cnt_d;
   logic             pulse_q, pulse_d;
   logic [SW_W-1:0]  sw_hold_q, sw_hold_d;
   logic [CNT_W-1:0] press_q, press_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         db_cnt_q  <= '0;
         pulse_q   <= 1'b0;
         sw_hold_q <= '0;
         press_q   <= '0;
      end else begin
         state_q   <= state_d;
         db_cnt_q  <= db_cnt_d;
         pulse_q   <= pulse_d;
         sw_hold_q <= sw_hold_d;
         press_q   <= press_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      db_cnt_d  = db_cnt_q;
      pulse_d   = 1'b0;
      sw_hold_d = sw_hold_q;
      press_d   = press_q;
      // Disable overrides everything, including a press about to be accepted.
      if (!ena) begin
         state_d  = StIdle;
         db_cnt_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (btn_s) begin
                  state_d  = StDbPress;
                  db_cnt_d = '0;
               end
            end
            StDbPress: begin
               if (!btn_s) begin
                  state_d  = StIdle;
                  db_cnt_d = '0;
               end else if (db_cnt_q == DbMax) begin
                  state_d   = StPressed;
                  db_cnt_d  = '0;
                  pulse_d   = 1'b1;
                  sw_hold_d = sw_s;
                  press_d   = press_q + CNT_W'(1);
               end else begin
                  db_cnt_d = db_cnt_q + DbW'(1);
               end
            end
            StPressed: begin
               if (!btn_s) begin
                  state_d  = StDbRelease;
                  db_cnt_d = '0;
               end
            end
            StDbRelease: begin
               if (btn_s) begin
                  state_d  = StPressed;
                  db_cnt_d = '0;
               end else if (db_cnt_q == DbMax) begin
                  state_d  = StIdle;
                  db_cnt_d = '0;
               end else begin
                  db_cnt_d = db_cnt_q + DbW'(1);
               end
            end
            default: begin
               state_d  = StIdle;
               db_cnt_d = '0;
            end
         endcase
      end
   end

   assign btn_pulse = pulse_q;
   assign sw_q      = sw_hold_q;
   assign press_cnt = press_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fsm_input_ctrl.sv
// Scoreboard bench for fsm_input_ctrl: a run-length model of the debounce rules predicts
// accepted presses; a monitor matches every DUT pulse against the predictions.
module tb_fsm_input_ctrl;

   localparam int unsigned DB = 4;
   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b1;
   logic          btn_raw = 1'b0;
   logic [2:0]    sw_raw = 3'b000;
   logic          btn_pulse;
   logic [2:0]    sw_q;
   logic [CW-1:0] press_cnt;
   logic          busy;

   fsm_input_ctrl #(
      .DB_CYCLES(DB),
      .CNT_W    (CW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .btn_raw  (btn_raw),
      .sw_raw   (sw_raw),
      .btn_pulse(btn_pulse),
      .sw_q     (sw_q),
      .press_cnt(press_cnt),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int sw;
      int cnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;

   // Reference model state: samples seen by the debouncer are the raw inputs two edges late.
   int   b1, b2, s1, s2;
   bit   armed;
   int   hi_run, lo_run;
   int   m_sw, m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      b1 = 0; b2 = 0; s1 = 0; s2 = 0;
      armed = 1'b1; hi_run = 0; lo_run = 0;
      m_sw = 0; m_cnt = 0;
   endtask

   // Model: a press is accepted after DB+1 consecutive high samples while armed; re-arming
   // needs DB+1 consecutive low samples. Disable re-arms immediately.
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            cyc++;
            if (!ena) begin
               armed = 1'b1; hi_run = 0; lo_run = 0;
            end else if (armed) begin
               if (b2 != 0) begin
                  hi_run++;
                  if (hi_run == DB + 1) begin
                     armed = 1'b0; hi_run = 0; lo_run = 0;
                     m_sw  = s2;
                     m_cnt = (m_cnt + 1) % (1 << CW);
                     q.push_back('{cyc: cyc, sw: m_sw, cnt: m_cnt});
                  end
               end else begin
                  hi_run = 0;
               end
            end else begin
               if (b2 == 0) begin
                  lo_run++;
                  if (lo_run == DB + 1) begin
                     armed = 1'b1; hi_run = 0;
                  end
               end else begin
                  lo_run = 0;
               end
            end
            b2 = b1; b1 = int'(btn_raw);
            s2 = s1; s1 = int'(sw_raw);
         end
      end
   end

   // Monitor: pops a prediction for every pulse; flags pulses that never came.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (btn_pulse) begin
               if (q.size() == 0) begin
                  check("spurious_pulse", 32'd1, 32'd0);
               end else begin
                  e = q.pop_front();
                  check("pulse_cycle", cyc, e.cyc);
                  check("pulse_sw_q", {29'd0, sw_q}, e.sw);
                  check("pulse_press_cnt", {30'd0, press_cnt}, e.cnt);
               end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
               check("missing_pulse", 32'd0, 32'd1);
               void'(q.pop_front());
            end
            check("sw_q_hold", {29'd0, sw_q}, m_sw);
            check("press_cnt", {30'd0, press_cnt}, m_cnt);
            check("busy", {31'd0, busy}, {31'd0, (!armed || hi_run > 0)});
         end
      end
   end

   task automatic hold(input logic b, input int n);
      btn_raw = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pulse"}, {31'd0, btn_pulse}, 32'd0);
      check({tag, "_sw_q"}, {29'd0, sw_q}, 32'd0);
      check({tag, "_press_cnt"}, {30'd0, press_cnt}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int len;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Clean press with a known switch value.
      sw_raw = 3'b101;
      hold(1'b1, 12);
      check("clean_sw_q", {29'd0, sw_q}, 32'd5);
      check("clean_press_cnt", {30'd0, press_cnt}, 32'd1);
      hold(1'b0, 10);

      // Bounce: no acceptance possible with 2-cycle high runs.
      sw_raw = 3'b010;
      for (int i = 0; i < 5; i++) begin
         hold(1'b1, 2);
         hold(1'b0, 2);
      end
      hold(1'b0, 10);
      check("bounce_press_cnt", {30'd0, press_cnt}, 32'd1);

      // Long hold with a release glitch.
      hold(1'b1, 100);
      hold(1'b0, 2);
      hold(1'b1, 2);
      hold(1'b0, 12);

      // Five presses to wrap the counter, switch changes between them.
      for (int i = 0; i < 5; i++) begin
         sw_raw = 3'($urandom_range(0, 7));
         hold(1'b1, 8);
         sw_raw = 3'($urandom_range(0, 7));
         hold(1'b0, 8);
      end

      // Drop enable on the edge that would have accepted the press.
      sw_raw = 3'b111;
      btn_raw = 1'b1;
      repeat (6) @(negedge clk);
      ena = 1'b0;
      repeat (2) @(negedge clk);
      btn_raw = 1'b0;
      repeat (3) @(negedge clk);
      ena = 1'b1;
      hold(1'b0, 8);

      // Asynchronous reset in the middle of release debounce.
      hold(1'b1, 10);
      hold(1'b0, 4);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midreset");
      q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      hold(1'b0, 4);

      // Switch motion while idle must not reach sw_q.
      for (int i = 0; i < 30; i++) begin
         sw_raw = 3'($urandom_range(0, 7));
         @(negedge clk);
      end

      // Random runs with occasional enable drops.
      for (int i = 0; i < 300; i++) begin
         len = int'($urandom_range(1, 12));
         sw_raw = 3'($urandom_range(0, 7));
         ena = ($urandom_range(0, 19) != 0);
         hold(1'($urandom_range(0, 1)), len);
      end
      ena = 1'b1;
      hold(1'b0, 20);
      check("queue_drained", q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
